counter_param: RTL and testbench
================================

COUNTER_PARAM -- requirements
Module: counter_param

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits; SHALL be 2 to 32.
REQ-002 Parameter MAX_VAL, default 255, terminal value; SHALL satisfy 1 <= MAX_VAL <= 2^WIDTH-1.
REQ-003 Port clk  input  1  single clock, all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port en  input  1  count enable.
REQ-006 Port clr  input  1  synchronous clear of count and ovf.
REQ-007 Port load  input  1  synchronous parallel load.
REQ-008 Port load_val  input  WIDTH  value for load.
REQ-009 Port up_dn  input  1  direction, 1 = up, 0 = down.
REQ-010 Port mode  input  1  boundary mode, 0 = wrap, 1 = saturate.
REQ-011 Port count  output  WIDTH  registered count value.
REQ-012 Port tc  output  1  registered one-cycle terminal-count pulse.
REQ-013 Port ovf  output  1  registered sticky boundary-hit flag, saturate mode only.

Function
REQ-014 Priority per edge SHALL be rst > clr > load > en; en=0 with no clr/load SHALL hold count and drive tc=0.
REQ-015 count SHALL reflect the new value in the cycle after the triggering edge, with no extra lag stage.
REQ-016 Up, en=1, count<MAX_VAL: count SHALL become count+1 and tc=0.
REQ-017 Up, en=1, count==MAX_VAL, wrap mode: count SHALL become 0 and tc=1 for one cycle.
REQ-018 Up, en=1, count==MAX_VAL, saturate mode: count SHALL hold MAX_VAL, tc=1 only on the first cycle reaching MAX_VAL, and ovf SHALL set.
REQ-019 Down, en=1, count>0: count SHALL become count-1 and tc=0.
REQ-020 Down, en=1, count==0, wrap mode: count SHALL become MAX_VAL and tc=1 for one cycle.
REQ-021 Down, en=1, count==0, saturate mode: count SHALL hold 0, ovf SHALL set, and tc SHALL follow the REQ-018 first-arrival rule.
REQ-022 load=1: count SHALL become min(load_val, MAX_VAL), tc=0, and ovf SHALL be unchanged.
REQ-023 clr=1: count SHALL become 0, tc=0, ovf=0, regardless of en/load.
REQ-024 Any count above MAX_VAL SHALL never be produced.
REQ-025 ovf SHALL remain set until clr or rst.
REQ-026 Changing up_dn or mode mid-count SHALL take effect on the next enabled edge with no glitch or skipped value.
REQ-027 Arithmetic SHALL be WIDTH bits unsigned; at MAX_VAL = 2^WIDTH-1 wrap SHALL NOT rely on natural overflow alone.

Reset
REQ-028 rst=1 at a rising edge SHALL set count=0, tc=0, ovf=0, overriding all other inputs.
REQ-029 rst asserted mid-count SHALL take effect at the next edge; counting SHALL resume from 0 on the first edge with rst=0 and en=1.
REQ-030 No output SHALL depend on an asynchronous path from rst.

Structure
REQ-031 Shared package counter_pkg SHALL hold the constants MODE_WRAP=0, MODE_SAT=1, DIR_DOWN=0 and DIR_UP=1.
REQ-032 counter_param SHALL be a single module with no sub-module.
REQ-033 Next-state logic SHALL be computed combinationally and stored in one clocked process for count, tc and ovf.

Verification
REQ-034 WIDTH=8, MAX_VAL=255, up, wrap, en=1 for 257 cycles from reset: count 0..255,0,1, with tc=1 only on the cycle count=0 after 255.
REQ-035 WIDTH=4, MAX_VAL=9, down, saturate, load 3 then en=1 for 6 cycles: count 3,2,1,0,0,0, tc pulses once, ovf=1 and stays set until clr.
REQ-036 WIDTH=4, MAX_VAL=9, load_val=14: count=9, then up wrap with en=1 gives 0 and tc=1.
REQ-037 Simultaneous rst=1, clr=1, load=1, en=1 with count=5 gives count=0; clr+load gives count=0 and ovf=0; load+en with load_val=7 gives count=7.
REQ-038 up_dn toggled at count=4 (MAX_VAL=9, wrap): sequence 3,4,3,2 with no skip; en=0 for 3 cycles holds the value and tc=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared encodings for the parameterised up/down counter.
//   MODE_*  : boundary behaviour selected by the 'mode' input
//   DIR_*   : count direction selected by the 'up_dn' input
package counter_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;

endpackage : counter_pkg

// File: rtl/counter_param.sv
// Parameterised up/down counter with wrap or saturate boundary handling.
//
// Parameters
//   WIDTH    counter width in bits (2..32)
//   MAX_VAL  terminal value, 1..2^WIDTH-1; count never exceeds it
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset (count=0, tc=0, ovf=0)
//   en        count enable
//   clr       synchronous clear of count and ovf
//   load      synchronous parallel load of min(load_val, MAX_VAL)
//   load_val  load value
//   up_dn     direction, DIR_UP / DIR_DOWN
//   mode      boundary mode, MODE_WRAP / MODE_SAT
//   count     registered count
//   tc        registered one-cycle terminal-count pulse
//   ovf       registered sticky flag: a saturate-mode count tried to pass a boundary
// Edge priority: rst > clr > load > en.
module counter_param
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_VAL = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up_dn,
  input  logic             mode,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 2 || WIDTH > 32) begin : gen_bad_width
    $error("counter_param: WIDTH must be 2..32");
  end
  if (MAX_VAL < 1 || (64'(MAX_VAL) >> WIDTH) != 64'd0) begin : gen_bad_max
    $error("counter_param: MAX_VAL must be 1..2^WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] cnt_inc, cnt_dec;

  assign cnt_inc = count_q + WIDTH'(1);
  assign cnt_dec = count_q - WIDTH'(1);

  // Boundaries are detected by explicit compares, so wrapping at MAX_VAL works the
  // same whether or not MAX_VAL is the all-ones value. In saturate mode tc marks
  // the edge that first arrives at the boundary; a further enabled edge sitting on
  // the boundary holds the count and raises ovf instead.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > MaxVal) ? MaxVal : load_val;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        if (count_q == MaxVal) begin
          if (mode == MODE_WRAP) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            ovf_d   = 1'b1;
          end
        end else begin
          count_d = cnt_inc;
          tc_d    = (mode == MODE_SAT) && (cnt_inc == MaxVal);
        end
      end else begin
        if (count_q == '0) begin
          if (mode == MODE_WRAP) begin
            count_d = MaxVal;
            tc_d    = 1'b1;
          end else begin
            ovf_d   = 1'b1;
          end
        end else begin
          count_d = cnt_dec;
          tc_d    = (mode == MODE_SAT) && (cnt_dec == '0);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule : counter_param

// File: tb/tb_counter_param.sv
// Self-checking bench for counter_param: two instances (8-bit/255 and 4-bit/9)
// compared every cycle against an arithmetic reference model, plus literal
// expectations for the documented scenarios.
module tb_counter_param;

  logic clk;
  bit   run;
  int   errors;
  int   checks;

  // Instance A: WIDTH=8, MAX_VAL=255
  logic       a_rst, a_en, a_clr, a_load, a_ud, a_md;
  logic [7:0] a_lv, a_count;
  logic       a_tc, a_ovf;
  // Instance B: WIDTH=4, MAX_VAL=9
  logic       b_rst, b_en, b_clr, b_load, b_ud, b_md;
  logic [3:0] b_lv, b_count;
  logic       b_tc, b_ovf;

  int ma_c, mb_c;
  bit ma_tc, ma_ovf, mb_tc, mb_ovf;

  counter_param #(.WIDTH(8), .MAX_VAL(255)) u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .clr(a_clr), .load(a_load), .load_val(a_lv),
    .up_dn(a_ud), .mode(a_md), .count(a_count), .tc(a_tc), .ovf(a_ovf)
  );

  counter_param #(.WIDTH(4), .MAX_VAL(9)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .clr(b_clr), .load(b_load), .load_val(b_lv),
    .up_dn(b_ud), .mode(b_md), .count(b_count), .tc(b_tc), .ovf(b_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the count lives on the ring 0..maxv. tc flags a wrap in wrap
  // mode, or arrival at the boundary in the count direction in saturate mode.
  task automatic model_step(input int maxv, input bit rst, input bit clr, input bit load,
                            input bit en, input bit ud, input bit md, input int lv,
                            inout int c, inout bit tc, inout bit ovf);
    int bound;
    if (rst || clr) begin
      c = 0; tc = 0; ovf = 0;
    end else if (load) begin
      c = (lv > maxv) ? maxv : lv;
      tc = 0;
    end else if (!en) begin
      tc = 0;
    end else if (!md) begin
      if (ud) begin
        tc = (c == maxv);
        c  = (c + 1) % (maxv + 1);
      end else begin
        tc = (c == 0);
        c  = (c + maxv) % (maxv + 1);
      end
    end else begin
      bound = ud ? maxv : 0;
      if (c == bound) begin
        ovf = 1; tc = 0;
      end else begin
        c  = ud ? c + 1 : c - 1;
        tc = (c == bound);
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(255, a_rst, a_clr, a_load, a_en, a_ud, a_md, int'(a_lv), ma_c, ma_tc, ma_ovf);
    model_step(9, b_rst, b_clr, b_load, b_en, b_ud, b_md, int'(b_lv), mb_c, mb_tc, mb_ovf);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (run) begin
      chk("a.count", int'(a_count), ma_c);
      chk("a.tc", int'(a_tc), int'(ma_tc));
      chk("a.ovf", int'(a_ovf), int'(ma_ovf));
      chk("b.count", int'(b_count), mb_c);
      chk("b.tc", int'(b_tc), int'(mb_tc));
      chk("b.ovf", int'(b_ovf), int'(mb_ovf));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic b_expect(input string name, input int c, input int t, input int o);
    chk({name, ".count"}, int'(b_count), c);
    chk({name, ".tc"}, int'(b_tc), t);
    chk({name, ".ovf"}, int'(b_ovf), o);
  endtask

  initial begin
    int exp_c [5];
    int exp_t [5];
    int exp_o [5];
    exp_c = '{2, 1, 0, 0, 0};
    exp_t = '{0, 0, 1, 0, 0};
    exp_o = '{0, 0, 0, 1, 1};

    errors = 0; checks = 0; run = 0;
    ma_c = 0; mb_c = 0; ma_tc = 0; mb_tc = 0; ma_ovf = 0; mb_ovf = 0;
    {a_rst, a_en, a_clr, a_load, a_ud, a_md} = 6'b100010;
    {b_rst, b_en, b_clr, b_load, b_ud, b_md} = 6'b100010;
    a_lv = '0; b_lv = '0;
    tick();
    run = 1;
    chk("reset.a.count", int'(a_count), 0);
    chk("reset.a.tc", int'(a_tc), 0);
    chk("reset.b.ovf", int'(b_ovf), 0);
    a_rst = 0; b_rst = 0;

    // 8-bit up/wrap full cycle plus two.
    a_en = 1; a_ud = 1; a_md = 0;
    for (int k = 1; k <= 257; k++) begin
      tick();
      chk("full.count", int'(a_count), k % 256);
      chk("full.tc", int'(a_tc), (k == 256) ? 1 : 0);
    end
    a_en = 0;

    // Down/saturate from a load of 3.
    b_load = 1; b_lv = 4'd3; b_md = 1; b_ud = 0;
    tick();
    b_expect("sat.load", 3, 0, 0);
    b_load = 0; b_en = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      b_expect("sat.step", exp_c[i], exp_t[i], exp_o[i]);
    end
    b_en = 0; b_load = 1; b_lv = 4'd5;
    tick();
    b_expect("sat.load_keeps_ovf", 5, 0, 1);
    b_load = 0; b_clr = 1;
    tick();
    b_expect("sat.clr", 0, 0, 0);
    b_clr = 0;

    // Over-range load clamps, then wraps up.
    b_md = 0; b_ud = 1; b_load = 1; b_lv = 4'd14;
    tick();
    b_expect("clamp.load", 9, 0, 0);
    b_load = 0; b_en = 1;
    tick();
    b_expect("clamp.wrap", 0, 1, 0);
    b_en = 0;

    // Priority combinations.
    b_load = 1; b_lv = 4'd5;
    tick();
    b_expect("prio.load5", 5, 0, 0);
    b_rst = 1; b_clr = 1; b_load = 1; b_en = 1; b_lv = 4'd7;
    tick();
    b_expect("prio.rst_all", 0, 0, 0);
    b_rst = 0; b_clr = 0; b_load = 0; b_en = 1; b_md = 1; b_ud = 0;
    tick();
    b_expect("prio.set_ovf", 0, 0, 1);
    b_clr = 1; b_load = 1; b_en = 0; b_lv = 4'd6;
    tick();
    b_expect("prio.clr_load", 0, 0, 0);
    b_clr = 0; b_load = 1; b_en = 1; b_lv = 4'd7; b_md = 0;
    tick();
    b_expect("prio.load_en", 7, 0, 0);

    // Direction change mid-count, then hold.
    b_load = 1; b_en = 0; b_lv = 4'd3;
    tick();
    b_expect("dir.load3", 3, 0, 0);
    b_load = 0; b_en = 1; b_ud = 1;
    tick();
    b_expect("dir.up4", 4, 0, 0);
    b_ud = 0;
    tick();
    b_expect("dir.down3", 3, 0, 0);
    tick();
    b_expect("dir.down2", 2, 0, 0);
    b_en = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      b_expect("hold", 2, 0, 0);
    end

    // Randomised traffic on both instances.
    for (int n = 0; n < 3000; n++) begin
      a_rst  = ($urandom_range(63) == 0);
      a_clr  = ($urandom_range(31) == 0);
      a_load = ($urandom_range(15) == 0);
      a_en   = ($urandom_range(3) != 0);
      a_lv   = 8'($urandom);
      if ($urandom_range(7) == 0) a_ud = ~a_ud;
      if ($urandom_range(7) == 0) a_md = ~a_md;
      b_rst  = ($urandom_range(63) == 0);
      b_clr  = ($urandom_range(31) == 0);
      b_load = ($urandom_range(15) == 0);
      b_en   = ($urandom_range(3) != 0);
      b_lv   = 4'($urandom);
      if ($urandom_range(7) == 0) b_ud = ~b_ud;
      if ($urandom_range(7) == 0) b_md = ~b_md;
      tick();
    end

    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_counter_param
